// File: rtl/det_adj_2x2_if.sv
// Handshake bus for det_adj_2x2: matrix in from upstream, adjugate and
// determinant out to the divider. master = upstream/downstream side,
// slave = the det_adj_2x2 block itself.
//   accept_in  : upstream presents a valid mat
//   accept_out : block idle and able to take mat
//   mat        : {a, b, c, d}, signed 16-bit each
//   ready_in   : divider can take a result
//   ready_out  : res/el/singular valid
//   res        : adjugate {d, -b, -c, a}
//   el         : determinant
//   singular   : el == 0
interface det_adj_2x2_if;
    logic        accept_in;
    logic        accept_out;
    logic [63:0] mat;
    logic        ready_in;
    logic        ready_out;
    logic [63:0] res;
    logic [15:0] el;
    logic        singular;

    modport master (
        output accept_in, mat, ready_in,
        input  accept_out, ready_out, res, el, singular
    );

    modport slave (
        input  accept_in, mat, ready_in,
        output accept_out, ready_out, res, el, singular
    );
endinterface

// File: rtl/det_adj_2x2.sv
// 2x2 fixed-point determinant and adjugate using one shared 16x16 multiplier.
// Ports: clk, reset (sync, active high), enable (global stall), bus (slave).
module det_adj_2x2 #(
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    det_adj_2x2_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    localparam logic signed [32:0] MAXV = 33'sd32767;
    localparam logic signed [32:0] MINV = -33'sd32768;

    state_t state;
    state_t state_nxt;

    logic signed [15:0] a, b, c, d;
    logic signed [31:0] p1;

    logic signed [15:0] mx, my;
    logic signed [31:0] prod;
    logic signed [32:0] diff;
    logic signed [32:0] shifted;
    logic        [15:0] det;

    // Negation in 17 bits so -(-32768) saturates to 32767.
    function automatic logic [15:0] neg_sat(input logic [15:0] x);
        logic signed [16:0] n;
        n = -$signed({x[15], x});
        if (n > 17'sd32767) return 16'h7FFF;
        return n[15:0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (enable)
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.accept_in) state_nxt = MUL1;
            MUL1: state_nxt = MUL2;
            MUL2: state_nxt = DONE;
            DONE: if (bus.ready_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        bus.accept_out = (state == IDLE) && !reset;
        bus.ready_out  = (state == DONE);
    end

    // Shared multiplier: a*d in MUL1, b*c otherwise (consumed in MUL2).
    always_comb begin
        mx   = (state == MUL1) ? a : b;
        my   = (state == MUL1) ? d : c;
        prod = mx * my;
    end

    // 33-bit difference cannot overflow; floor shift, then clamp to 16 bits.
    always_comb begin
        diff    = {p1[31], p1} - {prod[31], prod};
        shifted = diff >>> FRAC;
        if (shifted > MAXV)
            det = 16'h7FFF;
        else if (shifted < MINV)
            det = 16'h8000;
        else
            det = shifted[15:0];
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a            <= '0;
            b            <= '0;
            c            <= '0;
            d            <= '0;
            p1           <= '0;
            bus.res      <= '0;
            bus.el       <= '0;
            bus.singular <= 1'b0;
        end else if (enable) begin
            unique case (state)
                IDLE: begin
                    if (bus.accept_in) begin
                        a <= bus.mat[63:48];
                        b <= bus.mat[47:32];
                        c <= bus.mat[31:16];
                        d <= bus.mat[15:0];
                    end
                end
                MUL1: p1 <= prod;
                MUL2: begin
                    bus.el       <= det;
                    bus.singular <= (det == 16'h0000);
                    bus.res      <= {d, neg_sat(b), neg_sat(c), a};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_det_adj_2x2.sv
// Self-checking bench for det_adj_2x2: directed table, corner sequences
// and random matrices against an integer-arithmetic reference.
module tb_det_adj_2x2;

    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    det_adj_2x2_if bus ();

    det_adj_2x2 #(.FRAC(FRAC)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mat;
        logic [63:0] res;
        logic [15:0] el;
        logic        sing;
    } vec_t;

    vec_t vecs[7];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [15:0] clamp(input longint v);
        longint t;
        t = v;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t[15:0];
    endfunction

    // Reference: det = floor((ad - bc) / 2^FRAC), clamped; adj = [d -b; -c a].
    task automatic model(input logic [63:0] m, output logic [63:0] r,
                         output logic [15:0] e, output logic s);
        longint av, bv, cv, dv, q;
        av = sx(m[63:48]);
        bv = sx(m[47:32]);
        cv = sx(m[31:16]);
        dv = sx(m[15:0]);
        q  = (av * dv - bv * cv) >>> FRAC;
        e  = clamp(q);
        s  = (e == 16'h0);
        r  = {m[15:0], clamp(-bv), clamp(-cv), m[63:48]};
    endtask

    function automatic logic [15:0] rand16();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'(int'($urandom_range(0, 1023)) - 512);
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at a negedge with the block idle; returns at the negedge after
    // the capture edge.
    task automatic send(input logic [63:0] m);
        check("accept_out idle", 64'(bus.accept_out), 64'd1);
        bus.mat       = m;
        bus.accept_in = 1'b1;
        @(negedge clk);
        bus.accept_in = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 1;
        while (!bus.ready_out && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("ready_out seen", 64'(bus.ready_out), 64'd1);
    endtask

    task automatic transfer();
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.ready_in = 1'b0;
        check("ready_out after xfer", 64'(bus.ready_out), 64'd0);
        check("accept_out after xfer", 64'(bus.accept_out), 64'd1);
    endtask

    task automatic run_vec(input string name, input logic [63:0] m,
                           input logic [63:0] er, input logic [15:0] ee,
                           input logic es, input int hold);
        int lat;
        logic [63:0] r0;
        send(m);
        wait_ready(lat);
        check({name, " latency"}, 64'(lat), 64'd3);
        check({name, " res"}, bus.res, er);
        check({name, " el"}, 64'(bus.el), 64'(ee));
        check({name, " singular"}, 64'(bus.singular), 64'(es));
        r0 = bus.res;
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check({name, " held ready"}, 64'(bus.ready_out), 64'd1);
            check({name, " held res"}, bus.res, r0);
        end
        transfer();
    endtask

    initial begin
        logic [63:0] m, er, r0;
        logic [15:0] ee, e0;
        logic        es;
        int          lat;
        logic        stable;

        vecs[0] = '{64'h0200_0100_0100_0300, 64'h0300_FF00_FF00_0200, 16'h0500, 1'b0};
        vecs[1] = '{64'h0200_0400_0100_0200, 64'h0200_FC00_FF00_0200, 16'h0000, 1'b1};
        vecs[2] = '{64'h0000_8000_0100_0000, 64'h0000_7FFF_FF00_0000, 16'h7FFF, 1'b0};
        vecs[3] = '{64'h7FFF_0000_0000_7FFF, 64'h7FFF_0000_0000_7FFF, 16'h7FFF, 1'b0};
        vecs[4] = '{64'h0100_0000_0000_0100, 64'h0100_0000_0000_0100, 16'h0100, 1'b0};
        vecs[5] = '{64'h0100_0200_0300_0400, 64'h0400_FE00_FD00_0100, 16'hFE00, 1'b0};
        vecs[6] = '{64'h0001_0000_0000_FFFF, 64'hFFFF_0000_0000_0001, 16'hFFFF, 1'b0};

        reset         = 1'b1;
        enable        = 1'b1;
        bus.accept_in = 1'b0;
        bus.ready_in  = 1'b0;
        bus.mat       = '0;

        repeat (2) @(negedge clk);
        check("rst accept_out", 64'(bus.accept_out), 64'd0);
        check("rst ready_out", 64'(bus.ready_out), 64'd0);
        check("rst res", bus.res, 64'd0);
        check("rst el", 64'(bus.el), 64'd0);
        check("rst singular", 64'(bus.singular), 64'd0);
        reset = 1'b0;
        #1;
        check("accept_out after rst", 64'(bus.accept_out), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].mat, vecs[i].res,
                    vecs[i].el, vecs[i].sing, 0);

        // Back-pressure with a competing accept_in, then a stalled DONE.
        send(vecs[0].mat);
        wait_ready(lat);
        r0 = bus.res;
        e0 = bus.el;
        stable = 1'b1;
        bus.mat = 64'h1111_2222_3333_4444;
        bus.accept_in = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.ready_out || bus.res !== r0 || bus.el !== e0 ||
                bus.accept_out)
                stable = 1'b0;
        end
        bus.accept_in = 1'b0;
        check("bp stable", 64'(stable), 64'd1);
        enable = 1'b0;
        bus.ready_in = 1'b1;
        @(negedge clk);
        check("done stalled ready_out", 64'(bus.ready_out), 64'd1);
        enable = 1'b1;
        @(negedge clk);
        bus.ready_in = 1'b0;
        check("bp xfer ready_out", 64'(bus.ready_out), 64'd0);
        check("bp xfer accept_out", 64'(bus.accept_out), 64'd1);
        repeat (4) @(negedge clk);
        check("bp no capture", 64'(bus.ready_out), 64'd0);
        check("bp el hold", 64'(bus.el), 64'(e0));

        // Stall in MUL1 for 5 cycles.
        send(vecs[0].mat);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("stall no ready", 64'(bus.ready_out), 64'd0);
        enable = 1'b1;
        wait_ready(lat);
        check("stall latency", 64'(lat + 5), 64'd8);
        check("stall res", bus.res, vecs[0].res);
        check("stall el", 64'(bus.el), 64'(vecs[0].el));
        transfer();

        // Reset while in MUL2.
        send(vecs[5].mat);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst mid accept_out", 64'(bus.accept_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst mid ready_out", 64'(bus.ready_out), 64'd0);
        check("rst mid res", bus.res, 64'd0);
        check("rst mid el", 64'(bus.el), 64'd0);
        check("rst mid accept_out after", 64'(bus.accept_out), 64'd1);
        @(negedge clk);
        run_vec("after rst", vecs[0].mat, vecs[0].res, vecs[0].el,
                vecs[0].sing, 0);

        // Random matrices against the reference.
        for (int i = 0; i < 60; i++) begin
            m = {rand16(), rand16(), rand16(), rand16()};
            model(m, er, ee, es);
            run_vec($sformatf("rnd%0d", i), m, er, ee, es,
                    int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
